// File: rtl/ak_seq_pkg.sv
// ---------------------------------------------------------------------------
// ak_seq_pkg
// Shared definitions for the A/K1/K2 pattern sequencer:
//   - seq_state_e   : sequencer states IDLE..FIN
//   - PHASES        : number of A-level phases in one pattern (HI1, LO1, HI2, LO2)
//   - state_a_level : level driven on A in each state
//   - state_busy    : whether a state counts as "sequence in progress"
// ---------------------------------------------------------------------------
package ak_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI1   = 3'd1,
        LO1   = 3'd2,
        HI2   = 3'd3,
        LO2   = 3'd4,
        CHECK = 3'd5,
        FIN   = 3'd6
    } seq_state_e;

    localparam int PHASES = 4;

    function automatic logic state_a_level(input seq_state_e s);
        logic lvl;
        case (s)
            HI1:     lvl = 1'b1;
            HI2:     lvl = 1'b1;
            default: lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    // FIN is deliberately not busy so Done and Busy never overlap.
    function automatic logic state_busy(input seq_state_e s);
        logic b;
        case (s)
            HI1, LO1, HI2, LO2, CHECK: b = 1'b1;
            default:                   b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ak_pattern_seq_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Loadable down-counter that times one A-level phase.
// Ports:
//   i_clk      : rising-edge clock
//   i_rst_n    : synchronous active-low reset
//   i_load     : load i_load_val (priority over decrement)
//   i_load_val : value loaded on i_load (phase length minus one)
//   i_en       : decrement while non-zero
//   o_zero     : counter is zero (last cycle of the phase)
// ---------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [HOLD_W-1:0] i_load_val,
    input  logic              i_en,
    output logic              o_zero
);

    localparam logic [HOLD_W-1:0] ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    logic [HOLD_W-1:0] r_cnt;

    // Counter register: load wins, otherwise count down and stick at zero
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= {HOLD_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {HOLD_W{1'b0}})) begin
            r_cnt <= r_cnt - ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {HOLD_W{1'b0}});

endmodule

// File: rtl/ak_pattern_seq.sv
// ---------------------------------------------------------------------------
// ak_pattern_seq
// Stimulus sequencer / checker for the A/K1/K2 control FSM. On Start it
// drives A through HI1,LO1,HI2,LO2 (H cycles each) then one CHECK cycle,
// Cycles times, and checks that the FSM answered each pattern with K2 then K1.
// Build option: define AK_SEQ_CHECK_EN to enable the K1/K2 response check;
// without it K1/K2 are ignored, Err stays 0 and every pattern counts as good.
// Ports:
//   Clock     : rising-edge clock shared with the FSM
//   Reset     : synchronous active-low reset
//   Start     : one-cycle request, only honoured in IDLE
//   Hold      : cycles per A level (0 treated as 1), latched at Start
//   Cycles    : number of patterns, latched at Start
//   K1, K2    : FSM responses
//   A         : registered drive to the FSM's A input
//   Busy      : sequence in progress (HI1..CHECK)
//   Done      : one-cycle end-of-sequence pulse (FIN)
//   Err       : sticky missing-response flag, cleared at Start
//   DoneCount : patterns completed with correct responses, cleared at Start
// ---------------------------------------------------------------------------
import ak_seq_pkg::*;

module ak_pattern_seq #(
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [HOLD_W-1:0] Hold,
    input  logic [CNT_W-1:0]  Cycles,
    input  logic              K1,
    input  logic              K2,
    output logic              A,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [CNT_W-1:0]  DoneCount
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_eff;
    logic [HOLD_W-1:0] w_tmr_val;
    logic [CNT_W-1:0]  r_remain;
    logic [CNT_W-1:0]  w_remain_nxt;
    logic [CNT_W-1:0]  r_done_cnt;
    logic [CNT_W-1:0]  w_done_cnt_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_k1_seen;
    logic              w_k1_nxt;
    logic              r_k2_seen;
    logic              w_k2_nxt;
    logic              w_pattern_ok;
    logic              w_tmr_load;
    logic              w_tmr_en;
    logic              w_tmr_zero;
    logic              r_a;
    logic              r_busy;
    logic              r_done;

    assign w_hold_eff = (Hold == {HOLD_W{1'b0}}) ? HOLD_ONE : Hold;

`ifndef AK_SEQ_CHECK_EN
    logic w_unused_k;
    assign w_unused_k = K1 | K2;
`endif

    hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold_timer (
        .i_clk      (Clock),
        .i_rst_n    (Reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    // Next-state and next-value logic for the sequencer FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_remain_nxt   = r_remain;
        w_done_cnt_nxt = r_done_cnt;
        w_err_nxt      = r_err;
        w_k1_nxt       = r_k1_seen;
        w_k2_nxt       = r_k2_seen;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_tmr_val      = r_hold - HOLD_ONE;
`ifdef AK_SEQ_CHECK_EN
        // K responses may arrive in CHECK itself, so include this cycle's inputs.
        w_pattern_ok   = (r_k1_seen | K1) & (r_k2_seen | K2);
`else
        w_pattern_ok   = 1'b1;
`endif

        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_hold_nxt     = w_hold_eff;
                    w_remain_nxt   = Cycles;
                    w_done_cnt_nxt = {CNT_W{1'b0}};
                    w_err_nxt      = 1'b0;
                    w_k1_nxt       = 1'b0;
                    w_k2_nxt       = 1'b0;
                    w_tmr_val      = w_hold_eff - HOLD_ONE;
                    if (Cycles == {CNT_W{1'b0}}) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = HI1;
                        w_tmr_load  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HI1: begin
                if (w_tmr_zero) begin
                    w_state_nxt = LO1;
                    w_tmr_load  = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            LO1: begin
                if (w_tmr_zero) begin
                    w_state_nxt = HI2;
                    w_tmr_load  = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            HI2: begin
`ifdef AK_SEQ_CHECK_EN
                if (K2) begin
                    w_k2_nxt = 1'b1;
                end else begin
                    w_k2_nxt = r_k2_seen;
                end
`endif
                if (w_tmr_zero) begin
                    w_state_nxt = LO2;
                    w_tmr_load  = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            LO2: begin
`ifdef AK_SEQ_CHECK_EN
                w_k2_nxt = r_k2_seen | K2;
                w_k1_nxt = r_k1_seen | K1;
`endif
                if (w_tmr_zero) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            CHECK: begin
                w_k1_nxt = 1'b0;
                w_k2_nxt = 1'b0;
                if (w_pattern_ok) begin
                    if (r_done_cnt != {CNT_W{1'b1}}) begin
                        w_done_cnt_nxt = r_done_cnt + CNT_ONE;
                    end else begin
                        w_done_cnt_nxt = r_done_cnt;
                    end
                    w_remain_nxt = r_remain - CNT_ONE;
                    if (r_remain == CNT_ONE) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = HI1;
                        w_tmr_load  = 1'b1;
                    end
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_hold     <= HOLD_ONE;
            r_remain   <= {CNT_W{1'b0}};
            r_done_cnt <= {CNT_W{1'b0}};
            r_err      <= 1'b0;
            r_k1_seen  <= 1'b0;
            r_k2_seen  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_remain   <= w_remain_nxt;
            r_done_cnt <= w_done_cnt_nxt;
            r_err      <= w_err_nxt;
            r_k1_seen  <= w_k1_nxt;
            r_k2_seen  <= w_k2_nxt;
        end
    end

    // Output registers, decoded from the next state so they line up with it
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_a    <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_a    <= state_a_level(w_state_nxt);
            r_busy <= state_busy(w_state_nxt);
            r_done <= (w_state_nxt == FIN);
        end
    end

    assign A         = r_a;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Err       = r_err;
    assign DoneCount = r_done_cnt;

endmodule
